// File: rtl/sm_regview_pkg.sv
// Shared types and constants for the debug register-view controller.
// Address arithmetic wraps modulo the register-file size.
package sm_regview_pkg;

    localparam int ADDR_W  = 5;
    localparam int REG_CNT = 32;

    typedef enum logic {
        MANUAL,
        AUTO
    } mode_t;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CAPTURE
    } seq_t;

    function automatic logic [ADDR_W-1:0] addr_step(input logic [ADDR_W-1:0] addr,
                                                     input logic              up);
        int sum;
        sum = up ? int'(addr) + 1 : int'(addr) + REG_CNT - 1;
        return ADDR_W'(sum % REG_CNT);
    endfunction

endpackage

// File: rtl/sm_debounce.sv
// Push-button conditioner: 2-flop synchronizer, debounce counter and a
// one-cycle press pulse on an accepted high-to-low transition.
module sm_debounce #(
    parameter int DEB_W = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic in_n,
    output logic press
);

    logic             sync1;
    logic             sync2;
    logic             stable;
    logic             stable_d;
    logic [DEB_W-1:0] cnt;

    // NOTE: non-blocking assignments so every flop samples its pre-edge inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1    <= 1'b1;
            sync2    <= 1'b1;
            stable   <= 1'b1;
            stable_d <= 1'b1;
            cnt      <= '0;
            press    <= 1'b0;
        end else begin
            sync1    <= in_n;
            sync2    <= sync1;
            stable_d <= stable;
            press    <= stable_d & ~stable;
            if (sync2 != stable) begin
                if (cnt == '1) begin
                    stable <= sync2;
                    cnt    <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/sm_regview_ctrl.sv
// Debug register-view controller: steps the viewed register from keys or an
// auto-scan timer and keeps a periodically refreshed latch of its value.
module sm_regview_ctrl
    import sm_regview_pkg::*;
#(
    parameter int DEB_W     = 16,
    parameter int AUTO_W    = 24,
    parameter int REFRESH_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_next_n,
    input  logic              key_prev_n,
    input  logic              key_mode_n,
    output logic [ADDR_W-1:0] regAddr,
    input  logic [31:0]       regData,
    output logic [ADDR_W-1:0] viewAddr,
    output logic [31:0]       viewData,
    output logic              viewValid,
    output logic              autoMode
);

    logic                 press_next;
    logic                 press_prev;
    logic                 press_mode;
    mode_t                mode_q;
    seq_t                 seq_q;
    logic [AUTO_W-1:0]    auto_cnt;
    logic [REFRESH_W-1:0] ref_cnt;
    logic                 key_step;
    logic                 auto_wrap;
    logic                 addr_chg;
    logic                 ref_wrap;
    logic [ADDR_W-1:0]    next_addr;

    sm_debounce #(.DEB_W(DEB_W)) u_deb_next (.clk(clk), .rst(rst), .in_n(key_next_n), .press(press_next));
    sm_debounce #(.DEB_W(DEB_W)) u_deb_prev (.clk(clk), .rst(rst), .in_n(key_prev_n), .press(press_prev));
    sm_debounce #(.DEB_W(DEB_W)) u_deb_mode (.clk(clk), .rst(rst), .in_n(key_mode_n), .press(press_mode));

    // Opposing presses cancel; a key step outranks an auto wrap in the same cycle.
    assign key_step  = press_next ^ press_prev;
    assign auto_wrap = (mode_q == AUTO) && (&auto_cnt);
    assign addr_chg  = key_step | auto_wrap;
    assign next_addr = addr_step(viewAddr, key_step ? press_next : 1'b1);
    assign ref_wrap  = &ref_cnt;

    assign regAddr  = viewAddr;
    assign autoMode = (mode_q == AUTO);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q   <= MANUAL;
            auto_cnt <= '0;
            ref_cnt  <= '0;
            viewAddr <= '0;
        end else begin
            ref_cnt <= ref_cnt + 1'b1;
            if (press_mode)
                mode_q <= (mode_q == AUTO) ? MANUAL : AUTO;
            if (mode_q == MANUAL || press_mode || key_step)
                auto_cnt <= '0;
            else
                auto_cnt <= auto_cnt + 1'b1;
            if (addr_chg)
                viewAddr <= next_addr;
        end
    end

    // An address change always restarts the settle so a stale capture never lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seq_q     <= SETTLE;
            viewData  <= '0;
            viewValid <= 1'b0;
        end else if (addr_chg) begin
            seq_q     <= SETTLE;
            viewValid <= 1'b0;
        end else begin
            case (seq_q)
                IDLE:    if (ref_wrap) seq_q <= SETTLE;
                SETTLE:  seq_q <= CAPTURE;
                CAPTURE: begin
                    viewData  <= regData;
                    viewValid <= 1'b1;
                    seq_q     <= IDLE;
                end
                default: seq_q <= IDLE;
            endcase
        end
    end

endmodule
